// File: rtl/mult_shift_add.sv
// mult_shift_add: sequential shift-and-add unsigned multiplier, N iterations per product.
// Includes the carry-lookahead adder used for the per-iteration partial-product add.
module cla_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] sum,
    output logic         co
);
    logic [N-1:0] g, pr;
    logic [N:0] c;
    logic gg, pp;
    assign g = a & b;
    assign pr = a ^ b;
    // Each carry is a flat sum of products of generate/propagate terms, not a ripple chain.
    always_comb begin
        c = '0;
        gg = 1'b0;
        pp = 1'b0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            gg = g[i];
            pp = pr[i];
            for (int j = i - 1; j >= 0; j--) begin
                gg = gg | (pp & g[j]);
                pp = pp & pr[j];
            end
            c[i+1] = gg | (pp & ci);
        end
    end
    assign sum = pr ^ c[N-1:0];
    assign co = c[N];
endmodule

module mult_shift_add #(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [N-1:0] mcand, mult, acc_hi, add_sum, sum;
    logic [CW-1:0] count;
    logic add_co, c, last;

    cla_adder #(.N(N)) u_add (
        .a  (acc_hi),
        .b  (mcand),
        .ci (1'b0),
        .sum(add_sum),
        .co (add_co)
    );

    assign {c, sum} = mult[0] ? {add_co, add_sum} : {1'b0, acc_hi};
    assign last = count == CW'(N - 1);
    assign busy = state == RUN;
    assign done = state == DONE;

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        if (state == IDLE && start) state_nx = RUN;
        else if (state == RUN && last) state_nx = DONE;
        else if (state == DONE) state_nx = IDLE;
    end

    // The low half of the product shifts into mult as the multiplier bits retire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            mult   <= '0;
            acc_hi <= '0;
            count  <= '0;
            p      <= '0;
        end else if (state == IDLE && start) begin
            mcand  <= a;
            mult   <= b;
            acc_hi <= '0;
            count  <= '0;
        end else if (state == RUN) begin
            acc_hi <= {c, sum[N-1:1]};
            mult   <= {sum[0], mult[N-1:1]};
            count  <= count + CW'(1);
            if (last) p <= {c, sum, mult[N-1:1]};
        end
    end
endmodule

// File: tb/tb_mult_shift_add.sv
// tb_mult_shift_add: directed and exhaustive checks of mult_shift_add (N=4) against
// a cycle model of the control FSM and a scoreboard of expected products.
module tb_mult_shift_add;
    localparam int N = 4;
    localparam int W = 2 * N;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [N-1:0] a = '0, b = '0;
    logic busy, done;
    logic [W-1:0] p;
    int tests = 0, fails = 0;
    typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;
    mstate_t ms = M_IDLE;
    int mc = 0, accepts = 0, dones = 0, aborted = 0;
    logic [W-1:0] mp = '0;
    logic [W-1:0] q[$];

    always #5 clock = ~clock;

    mult_shift_add #(.N(N)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .p    (p)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: predict acceptance, advance the model at the edge, compare at the falling edge.
    task automatic cyc();
        bit acc;
        acc = ms == M_IDLE && start && !reset;
        if (acc) begin
            q.push_back(W'(a) * W'(b));
            accepts++;
        end
        @(posedge clock);
        if (reset) begin
            ms = M_IDLE;
            mc = 0;
            mp = '0;
        end else case (ms)
            M_IDLE: if (acc) begin ms = M_RUN; mc = 0; end
            M_RUN: if (mc == N - 1) begin
                ms = M_DONE;
                chk("sb_nonempty", q.size() > 0, 1);
                if (q.size() > 0) mp = q.pop_front();
            end else mc++;
            default: ms = M_IDLE;
        endcase
        @(negedge clock);
        chk("busy", busy, ms == M_RUN);
        chk("done", done, ms == M_DONE);
        chk("p", p, mp);
        chk("busy_done_excl", busy & done, 0);
        if (done) dones++;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && (busy || done); i++) cyc();
        chk("idle_timeout", busy | done, 0);
    endtask

    task automatic op(input logic [N-1:0] x, input logic [N-1:0] y);
        a = x;
        b = y;
        start = 1'b1;
        cyc();
        start = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        wait_idle();
    endtask

    initial begin
        #3;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_p", p, 0);
        cyc();
        reset = 1'b0;
        op(4'd15, 4'd15);
        chk("p_15x15", p, 8'hE1);
        op(4'd13, 4'd11);
        chk("p_13x11", p, 143);
        op(4'd0, 4'd9);
        chk("p_0x9", p, 0);
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        repeat (20) cyc();
        start = 1'b0;
        wait_idle();
        chk("p_3x5_held", p, 15);
        a = 4'd7;
        b = 4'd6;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        a = 4'd15;
        b = 4'd15;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_idle();
        chk("p_7x6_ignore", p, 42);
        a = 4'd9;
        b = 4'd9;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_p", p, 0);
        aborted += q.size();
        q.delete();
        ms = M_IDLE;
        mc = 0;
        mp = '0;
        cyc();
        reset = 1'b0;
        repeat (3) cyc();
        op(4'd2, 4'd3);
        chk("p_2x3", p, 6);
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++) op(N'(i), N'(j));
        chk("done_count", dones, accepts - aborted);
        chk("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
